// File: rtl/agex_muldiv_unit.sv
// RV32M multiply/divide unit for the AGEX stage. It accepts one M-op over a valid/ready
// handshake and holds the pipeline until the result is taken. Multiplies finish after a
// fixed latency. Divides are radix-2 restoring, with a fast path for the divide special cases.
module agex_muldiv_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned MUL_LATENCY = 3,
    parameter int unsigned TAG_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [4:0]       in_rd,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [4:0]       out_rd,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_q, rd_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvsr_q, dvsr_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              isrem_q, isrem_d;

    logic              accept;
    logic              mul_sa, mul_sb;
    logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
    logic [XLEN-1:0]   mul_res;
    logic              div_signed, neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     step_sh, step_diff;
    logic              step_ge;
    logic [XLEN-1:0]   step_rem, step_quo, fin_q, fin_r, fin;

    // Multiply is formed directly from the issued operands; the latency counter only
    // delays its presentation.
    always_comb begin
        mul_sa  = (in_op[1:0] != 2'd3);
        mul_sb  = (in_op[1] == 1'b0);
        mul_a   = {{XLEN{mul_sa & in_rs1[XLEN-1]}}, in_rs1};
        mul_b   = {{XLEN{mul_sb & in_rs2[XLEN-1]}}, in_rs2};
        mul_p   = mul_a * mul_b;
        mul_res = (in_op[1:0] == 2'd0) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
    end

    // Divide operand preparation and special-case detection at issue time.
    always_comb begin
        div_signed = ~in_op[0];
        neg_a      = div_signed & in_rs1[XLEN-1];
        neg_b      = div_signed & in_rs2[XLEN-1];
        mag_a      = neg_a ? -in_rs1 : in_rs1;
        mag_b      = neg_b ? -in_rs2 : in_rs2;
        div_zero   = (in_rs2 == '0);
        div_ovf    = div_signed && (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);
    end

    // One restoring-division step, plus the sign fixup applied on the final step.
    always_comb begin
        step_sh   = {rem_q, quo_q[XLEN-1]};
        step_diff = step_sh - {1'b0, dvsr_q};
        step_ge   = ~step_diff[XLEN];
        step_rem  = step_ge ? step_diff[XLEN-1:0] : step_sh[XLEN-1:0];
        step_quo  = {quo_q[XLEN-2:0], step_ge};
        fin_q     = qneg_q ? -step_quo : step_quo;
        fin_r     = rneg_q ? -step_rem : step_rem;
        fin       = isrem_q ? fin_r : fin_q;
    end

    // Next-state and datapath update; flush overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rd_d     = rd_q;
        tag_d    = tag_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        isrem_d  = isrem_q;
        accept   = in_valid && (state_q == StIdle) && !flush;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    rd_d  = in_rd;
                    tag_d = in_tag;
                    if (!in_op[2]) begin
                        result_d = mul_res;
                        cnt_d    = CntW'(MUL_LATENCY - 1);
                        state_d  = (MUL_LATENCY == 1) ? StDone : StMul;
                    end else begin
                        isrem_d = in_op[1];
                        if (div_zero) begin
                            result_d = in_op[1] ? in_rs1 : '1;
                            state_d  = StDone;
                        end else if (div_ovf) begin
                            result_d = in_op[1] ? '0 : in_rs1;
                            state_d  = StDone;
                        end else begin
                            quo_d   = mag_a;
                            rem_d   = '0;
                            dvsr_d  = mag_b;
                            qneg_d  = neg_a ^ neg_b;
                            rneg_d  = neg_a;
                            cnt_d   = CntW'(XLEN);
                            state_d = StDiv;
                        end
                    end
                end
            end
            StMul: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDiv: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    result_d = fin;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            state_d = StIdle;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
            tag_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            isrem_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            tag_q    <= tag_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            isrem_q  <= isrem_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign out_valid  = (state_q == StDone);
    assign out_result = result_q;
    assign out_rd     = rd_q;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_agex_muldiv_unit.sv
// Randomised and directed bench for agex_muldiv_unit against an arithmetic reference model.
module tb_agex_muldiv_unit;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned MUL_LATENCY = 3;
    localparam int unsigned TAG_W       = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = '0;
    logic [XLEN-1:0]  in_rs1 = '0;
    logic [XLEN-1:0]  in_rs2 = '0;
    logic [4:0]       in_rd = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  out_result;
    logic [4:0]       out_rd;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    agex_muldiv_unit #(
        .XLEN        (XLEN),
        .MUL_LATENCY (MUL_LATENCY),
        .TAG_W       (TAG_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // RISC-V M semantics expressed with ordinary integer arithmetic.
    function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        int          sa;
        int          sb;
        longint      sp;
        logic [63:0] up;
        logic        ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin
                sp = longint'(sa) * longint'(sb);
                return sp[31:0];
            end
            3'd1: begin
                sp = longint'(sa) * longint'(sb);
                return sp[63:32];
            end
            3'd2: begin
                sp = longint'(sa) * longint'({32'd0, b});
                return sp[63:32];
            end
            3'd3: begin
                up = {32'd0, a} * {32'd0, b};
                return up[63:32];
            end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        if (op < 3'd4) return int'(MUL_LATENCY);
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return int'(XLEN) + 1;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Present one op and return just after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] tag);
        int w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!in_ready) check("issue_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_rd    = rd;
        in_tag   = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int bp);
        logic [31:0] exp;
        logic [4:0]  rd;
        logic [31:0] tag;
        int          exp_lat;
        int          lat;
        rd      = 5'($urandom);
        tag     = 32'($urandom);
        exp     = model_result(op, a, b);
        exp_lat = model_latency(op, a, b);
        issue(op, a, b, rd, tag);
        check("busy_after_accept", 64'(busy), 64'd1);
        check("in_ready_after_accept", 64'(in_ready), 64'd0);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("latency op%0d", op), 64'(lat), 64'(exp_lat));
        check($sformatf("result op%0d %h %h", op, a, b), 64'(out_result), 64'(exp));
        check("out_rd", 64'(out_rd), 64'(rd));
        check("out_tag", 64'(out_tag), 64'(tag));
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_result", 64'(out_result), 64'(exp));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_after_transfer", 64'(in_ready), 64'd1);
        check("valid_drop_after_transfer", 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic saw;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 4);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run_op(3'd4, 32'hFFFF_FFEC, 32'd3, 0);
        run_op(3'd6, 32'hFFFF_FFEC, 32'd3, 0);
        run_op(3'd5, 32'd100, 32'd7, 0);
        run_op(3'd7, 32'd100, 32'd7, 2);
        run_op(3'd5, 32'd5, 32'd0, 0);
        run_op(3'd7, 32'd5, 32'd0, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // Flush in the middle of a divide
        issue(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd9, 32'h55);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_busy", 64'(busy), 64'd0);
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) saw = 1'b1;
        end
        check("flush_no_valid_later", 64'(saw), 64'd0);

        // Flush with in_valid in IDLE blocks the accept
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_rs1   = 32'd2;
        in_rs2   = 32'd3;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_blocks_accept_busy", 64'(busy), 64'd0);
        check("flush_blocks_accept_ready", 64'(in_ready), 64'd1);
        saw = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_valid) saw = 1'b1;
        end
        check("flush_blocks_accept_valid", 64'(saw), 64'd0);

        // Reset during a divide
        issue(3'd4, 32'd1000, 32'd7, 5'd17, 32'hABCD);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_result", 64'(out_result), 64'd0);
        check("midrst_out_rd", 64'(out_rd), 64'd0);
        check("midrst_out_tag", 64'(out_tag), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        run_op(3'd0, 32'd3, 32'd4, 0);

        // Random ops against the model
        for (int n = 0; n < 40; n++) begin
            run_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
                   int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
